// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a 4x4 active-low matrix keypad. Each row is driven low in turn,
//   the columns pass through a 2-flop synchroniser, and an FSM debounces
//   each press and each release. A debounced press latches the key code,
//   sets a sticky valid flag and bumps an 8-bit press counter.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_col_n[3:0] keypad columns, active-low, asynchronous to i_clk
//   i_key_clr    1-cycle pulse, clears the sticky valid flag
//   o_row_n[3:0] row drive, one-hot active-low
//   o_key_word   [3:0] key code, [7] valid (sticky), [15:8] press count
//   o_col_live   synchronised columns, active-high
//   o_key_irq    1-cycle pulse alongside each key_word latch update
//                (only when KEYPAD_SCAN_IRQ_EN is defined)
//
// Build option: define KEYPAD_SCAN_IRQ_EN to add o_key_irq.

module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_col_n,
    input  logic        i_key_clr,
    output logic [3:0]  o_row_n,
    output logic [31:0] o_key_word,
    output logic [3:0]  o_col_live
`ifdef KEYPAD_SCAN_IRQ_EN
    ,
    output logic        o_key_irq
`endif
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DBC_W = $clog2(DEBOUNCE_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_GATE = DIV_W'(2);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       col_meta, col_sync, snap;
    logic [DIV_W-1:0] div;
    logic [DBC_W-1:0] dbc;
    logic [1:0]       row, col_idx;
    logic [3:0]       code;
    logic             valid;
    logic [7:0]       count;

    logic col_idle, snap_match;
    logic detect, scan_end, latch, rel_start, rel_done, row_adv, dbc_inc;

    assign col_idle   = (col_sync == 4'hF);
    assign snap_match = (col_sync == snap);

    // Lowest low column wins when several are pressed on one row.
    always_comb begin
        casez (snap)
            4'b???0: col_idx = 2'd0;
            4'b??01: col_idx = 2'd1;
            4'b?011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_meta   <= '1;
            col_sync   <= '1;
            o_col_live <= '0;
        end else begin
            col_meta   <= i_col_n;
            col_sync   <= col_meta;
            o_col_live <= ~col_sync;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= SCAN;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            SCAN:     if (div >= DIV_GATE && !col_idle) state_nxt = DEBOUNCE;
            DEBOUNCE: if (!snap_match)                  state_nxt = SCAN;
                      else if (dbc == DBC_LAST)         state_nxt = PRESSED;
            PRESSED:  if (col_idle)                     state_nxt = RELEASE;
            RELEASE:  if (!col_idle)                    state_nxt = PRESSED;
                      else if (dbc == DBC_LAST)         state_nxt = SCAN;
            default:                                    state_nxt = SCAN;
        endcase
    end

    // FSM: control strobes
    always_comb begin
        detect    = (state == SCAN) && (div >= DIV_GATE) && !col_idle;
        scan_end  = (state == SCAN) && !detect && (div == DIV_LAST);
        latch     = (state == DEBOUNCE) && snap_match && (dbc == DBC_LAST);
        rel_start = (state == PRESSED) && col_idle;
        rel_done  = (state == RELEASE) && col_idle && (dbc == DBC_LAST);
        row_adv   = scan_end || rel_done;
        dbc_inc   = ((state == DEBOUNCE) && snap_match) ||
                    ((state == RELEASE) && col_idle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div     <= '0;
            dbc     <= '0;
            snap    <= '1;
            row     <= '0;
            o_row_n <= 4'b1110;
            code    <= '0;
            count   <= '0;
        end else begin
            // div only runs while scanning; any exit from SCAN leaves it at 0
            if (state != SCAN || detect || row_adv) div <= '0;
            else                                    div <= div + 1'b1;

            if (detect || rel_start) dbc <= DBC_W'(1);
            else if (dbc_inc)        dbc <= dbc + 1'b1;

            if (detect) snap <= col_sync;

            if (row_adv) begin
                row     <= row + 1'b1;
                o_row_n <= {o_row_n[2:0], o_row_n[3]};
            end

            if (latch) begin
                code  <= {row, col_idx};
                count <= count + 1'b1;
            end
        end
    end

    // A latch outranks a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       valid <= 1'b0;
        else if (latch)     valid <= 1'b1;
        else if (i_key_clr) valid <= 1'b0;
    end

    assign o_key_word = {16'h0000, count, valid, 3'b000, code};

`ifdef KEYPAD_SCAN_IRQ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_key_irq <= 1'b0;
        else          o_key_irq <= latch;
    end
`endif

endmodule
